alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Moore-style control unit that sequences the phase-1 datapath through fetch, decode and execute for three-register ALU/shift instructions. Instructions have the form ra <= rb OP rc.
- Drives the datapath's bus-out selects, register enables, memory read strobe and ALU op_code.
- Waits on a memory-ready handshake during fetch.
- Reports busy, halt and fault status, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15: maximum T1 cycles spent waiting for mem_ready before a fault is raised.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- start  in  1  pulse; in IDLE, begins fetching at the current PC.
- run  in  1  level; while 1, the sequencer fetches the next instruction after T5; when 0, it returns to IDLE.
- mem_ready  in  1  memory data valid on m_data_in; sampled only in T1.
- ir_data  in  32  IR register contents. Field map: op = [31:27], ra = [26:23], rb = [22:19], rc = [18:15].
- pc_out, mdr_out, zlo_out  out  1 each  bus source selects.
- mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_increment, read  out  1 each  datapath strobes.
- r_out  out  16  one-hot general-register bus select.
- r_enable  out  16  one-hot general-register load enable.
- op_code  out  5  ALU operation.
- busy  out  1  state is not IDLE, HALT or FAULT.
- halted  out  1  HALT instruction executed.
- fault  out  1  illegal opcode or memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: clr sampled high forces state to IDLE, clears the wait counter and retired, and forces every output to 0. clr has priority over all other inputs, including mid-instruction; a partially executed instruction is abandoned with no register write.
- Outputs are decoded purely from the registered state and ir_data. There is no combinational path from start, run or mem_ready to any output.

States and actions (all strobes not listed are 0):
- IDLE: no outputs asserted.
  - start = 1 -> T0. Otherwise stay.
- T0: pc_out, mar_enable, pc_increment.
  - Always -> T1.
- T1: read, mdr_enable, held every cycle in this state.
  - mem_ready = 1 -> T2.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - The wait counter clears on entry to T1.
- T2: mdr_out, ir_enable.
  - Always -> DEC.
- DEC: no strobes. ir_data is now valid.
  - op in 3..11 (ALU class) -> T3.
  - op = 27 (nop) -> RET.
  - op = 28 (halt) -> HALT.
  - Any other op -> FAULT.
- T3: r_out[rb], y_enable.
- T4: r_out[rc], z_enable, op_code = op.
  - op_code is 0 in every other state.
- T5: zlo_out, r_enable[ra].
  - r0 is writable.
  - ra = rb or ra = rc is legal, because operands are latched in Y and Z before the write.
- RET: retired increments by 1 and wraps modulo 2^CNT_W.
  - run = 1 -> T0. run = 0 -> IDLE.
  - T5 always proceeds to RET, so every completed ALU instruction and every nop passes through RET exactly once.
- HALT: halted = 1. Terminal until clr.
  - A halt instruction does not count as retired.
- FAULT: fault = 1. Terminal until clr.

Timing and handshake rules:
- ALU instruction latency with mem_ready already high in the first T1 cycle: T0, T1, T2, DEC, T3, T4, T5, RET = 8 cycles.
- Each T1 wait cycle adds 1.
- start outside IDLE is ignored.
- run dropping mid-instruction lets the current instruction complete; the sequencer then goes to IDLE from RET.
- mem_ready outside T1 is ignored.
- r_out and r_enable are never asserted together, and at most one bus source is active in any state.

Decomposition:
- Package seq_pkg:
  - state enum: IDLE, T0, T1, T2, DEC, T3, T4, T5, RET, HALT, FAULT.
  - opcode constants: OP_ALU_MIN = 3, OP_ALU_MAX = 11, OP_NOP = 27, OP_HALT = 28.
  - IR field bit positions.
- One sub-module, dec_4_to_16, is the natural split. Instantiate it twice:
  - First instance: operand select, with rb in T3 and rc in T4, gated onto r_out.
  - Second instance: ra, gated by T5, onto r_enable.

Test Plan:
- Reset mid-instruction: clr asserted in T4 -> next cycle state is IDLE, all outputs 0, retired = 0, and no r_enable pulse ever occurs.
- Single instruction: ir_data = {5'd5, 4'd1, 4'd2, 4'd3, 15'b0}, start pulse, run = 0, mem_ready = 1 -> sequence below, then IDLE.
  - Cycle-exact strobe sequence: T3 asserts r_out = 16'h0004; T4 asserts r_out = 16'h0008 with op_code = 5; T5 asserts r_enable = 16'h0002.
  - After RET: retired = 1, busy = 0.
- Memory wait: mem_ready held low for 3 cycles in T1 -> read and mdr_enable stay high for 4 cycles; total instruction takes 11 cycles.
- Timeout: mem_ready held at 0 -> fault = 1 after exactly MEM_TIMEOUT = 15 T1 cycles; sequencer stays in FAULT until clr.
- Continuous run: run = 1, three ALU instructions then a halt (op = 28) -> retired = 3, halted = 1, busy = 0.
- Illegal opcode: op = 20 -> fault = 1 right after DEC, with no r_out or r_enable activity; start is then ignored until clr.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, opcode map,
// IR field layout and the bundle of registered control strobes.
package seq_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, DEC, T3, T4, T5, RET, HALT, FAULT
  } state_e;

  localparam logic [4:0] OP_ALU_MIN = 5'd3;
  localparam logic [4:0] OP_ALU_MAX = 5'd11;
  localparam logic [4:0] OP_NOP     = 5'd27;
  localparam logic [4:0] OP_HALT    = 5'd28;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } ir_fields_t;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       zlo_out;
    logic       mar_enable;
    logic       mdr_enable;
    logic       ir_enable;
    logic       y_enable;
    logic       z_enable;
    logic       pc_increment;
    logic       read;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [4:0] op_code;
  } ctrl_t;

  function automatic ir_fields_t ir_unpack(input logic [31:0] ir);
    ir_fields_t f;
    f.op = ir[IR_OP_LSB +: 5];
    f.ra = ir[IR_RA_LSB +: 4];
    f.rb = ir[IR_RB_LSB +: 4];
    f.rc = ir[IR_RC_LSB +: 4];
    return f;
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
  endfunction

endpackage

// File: rtl/dec_4_to_16.sv
// One-hot 4-to-16 decoder with enable; all outputs low when disabled.
module dec_4_to_16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] y
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control unit for three-register ALU instructions.
// All outputs are registered, computed from the next state and the IR fields.
module alu_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir_data,
  output logic             pc_out,
  output logic             mdr_out,
  output logic             zlo_out,
  output logic             mar_enable,
  output logic             mdr_enable,
  output logic             ir_enable,
  output logic             y_enable,
  output logic             z_enable,
  output logic             pc_increment,
  output logic             read,
  output logic [15:0]      r_out,
  output logic [15:0]      r_enable,
  output logic [4:0]       op_code,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ir_fields_t        ir;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [15:0]       r_out_q, r_out_d;
  logic [15:0]       r_enable_q, r_enable_d;

  logic [3:0]        operand_sel;
  logic              operand_en;
  logic              write_en;
  logic              unused_ir_bits;

  assign ir             = ir_unpack(ir_data);
  assign unused_ir_bits = ^ir_data[14:0];

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: if (start) state_d = T0;
      T0: begin
        state_d = T1;
        wait_d  = '0;
      end
      T1: begin
        if (mem_ready)                                 state_d = T2;
        else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1))   state_d = FAULT;
        else                                           wait_d  = wait_q + 1'b1;
      end
      T2:  state_d = DEC;
      DEC: begin
        if (is_alu_op(ir.op))      state_d = T3;
        else if (ir.op == OP_NOP)  state_d = RET;
        else if (ir.op == OP_HALT) state_d = HALT;
        else                       state_d = FAULT;
      end
      T3:  state_d = T4;
      T4:  state_d = T5;
      T5:  state_d = RET;
      RET: begin
        retired_d = retired_q + 1'b1;
        state_d   = run ? T0 : IDLE;
      end
      HALT, FAULT: state_d = state_q;
      default:     state_d = FAULT;
    endcase
  end

  // Register selects come from the decoders; the operand decoder carries rb
  // into T3 and rc into T4, the write decoder carries ra into T5.
  assign operand_sel = (state_d == T3) ? ir.rb : ir.rc;
  assign operand_en  = (state_d == T3) || (state_d == T4);
  assign write_en    = (state_d == T5);

  dec_4_to_16 u_operand_dec (
    .sel (operand_sel),
    .en  (operand_en),
    .y   (r_out_d)
  );

  dec_4_to_16 u_write_dec (
    .sel (ir.ra),
    .en  (write_en),
    .y   (r_enable_d)
  );

  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      T0: begin
        ctrl_d.pc_out       = 1'b1;
        ctrl_d.mar_enable   = 1'b1;
        ctrl_d.pc_increment = 1'b1;
      end
      T1: begin
        ctrl_d.read       = 1'b1;
        ctrl_d.mdr_enable = 1'b1;
      end
      T2: begin
        ctrl_d.mdr_out   = 1'b1;
        ctrl_d.ir_enable = 1'b1;
      end
      T3: ctrl_d.y_enable = 1'b1;
      T4: begin
        ctrl_d.z_enable = 1'b1;
        ctrl_d.op_code  = ir.op;
      end
      T5:      ctrl_d.zlo_out = 1'b1;
      HALT:    ctrl_d.halted  = 1'b1;
      FAULT:   ctrl_d.fault   = 1'b1;
      default: ;
    endcase
    ctrl_d.busy = !(state_d inside {IDLE, HALT, FAULT});
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      retired_q  <= '0;
      ctrl_q     <= '0;
      r_out_q    <= '0;
      r_enable_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      ctrl_q     <= ctrl_d;
      r_out_q    <= r_out_d;
      r_enable_q <= r_enable_d;
    end
  end

  assign pc_out       = ctrl_q.pc_out;
  assign mdr_out      = ctrl_q.mdr_out;
  assign zlo_out      = ctrl_q.zlo_out;
  assign mar_enable   = ctrl_q.mar_enable;
  assign mdr_enable   = ctrl_q.mdr_enable;
  assign ir_enable    = ctrl_q.ir_enable;
  assign y_enable     = ctrl_q.y_enable;
  assign z_enable     = ctrl_q.z_enable;
  assign pc_increment = ctrl_q.pc_increment;
  assign read         = ctrl_q.read;
  assign op_code      = ctrl_q.op_code;
  assign busy         = ctrl_q.busy;
  assign halted       = ctrl_q.halted;
  assign fault        = ctrl_q.fault;
  assign r_out        = r_out_q;
  assign r_enable     = r_enable_q;
  assign retired      = retired_q;

endmodule
